// File: rtl/phase_acq_pkg.sv
// Shared definitions for the phase acquisition controller: state encoding and
// the max(x,1) clamp used for the settle and decimation lengths.
package phase_acq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  function automatic logic [31:0] clamp1(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/phase_acq_ctrl_axis_out_slot.sv
// Single-entry AXI-Stream output register. A new sample loads only when the slot
// is empty or being drained this cycle; otherwise it is reported as dropped.
module axis_out_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_last,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_last,
  output logic         o_valid,
  output logic         o_drop
);

  logic [W-1:0] r_data;
  logic         r_last;
  logic         r_valid;
  logic         w_free;

  assign w_free = !r_valid || i_ready;
  assign o_drop = i_load && !w_free;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load && w_free) begin
      r_data  <= i_data;
      r_last  <= i_last;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_valid = r_valid;

endmodule

// File: rtl/phase_acq_ctrl.sv
// Phase acquisition sequencer: settle with accumulation off, then run with
// decimated capture of the unwrapped phase into an AXI-Stream slot.
//   state     | meaning
//   ST_IDLE   | waiting for start, acc_on low
//   ST_SETTLE | settle timer counting down, acc_on low
//   ST_RUN    | acc_on high, decimated captures until n_records or stop
module phase_acq_ctrl
  import phase_acq_pkg::*;
#(
  parameter int DOUT_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         stop,
  input  logic [CNT_WIDTH-1:0]         n_settle,
  input  logic [CNT_WIDTH-1:0]         n_decim,
  input  logic [CNT_WIDTH-1:0]         n_records,
  input  logic signed [DOUT_WIDTH-1:0] phase_in,
  output logic                         acc_on,
  output logic [DOUT_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         busy,
  output logic                         overflow
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_settle_cnt;
  logic [CNT_WIDTH-1:0] r_decim_m1;
  logic [CNT_WIDTH-1:0] r_nrec;
  logic [CNT_WIDTH-1:0] r_d;
  logic [CNT_WIDTH-1:0] r_rec_cnt;
  logic                 r_acc_on;
  logic                 r_overflow;
  logic [CNT_WIDTH-1:0] w_settle_init;
  logic [CNT_WIDTH-1:0] w_decim_init;
  logic                 w_start_ok;
  logic                 w_capture;
  logic                 w_final;
  logic                 w_drop;

  assign w_settle_init = CNT_WIDTH'(clamp1(32'(n_settle)) - 32'd1);
  assign w_decim_init  = CNT_WIDTH'(clamp1(32'(n_decim)) - 32'd1);

  // stop wins over a coincident start and also suppresses a same-cycle capture
  assign w_start_ok = (r_state == ST_IDLE) && start && !stop;
  assign w_capture  = (r_state == ST_RUN) && !stop && (r_d == r_decim_m1);
  assign w_final    = w_capture && (r_nrec != '0) &&
                      (r_rec_cnt == r_nrec - CNT_WIDTH'(1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (stop)                    w_state_nxt = ST_IDLE;
        else if (r_settle_cnt == '0) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop || w_final) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_decim_m1   <= '0;
      r_nrec       <= '0;
      r_d          <= '0;
      r_rec_cnt    <= '0;
      r_acc_on     <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc_on <= (w_state_nxt == ST_RUN);
      if (w_drop) r_overflow <= 1'b1;
      if (w_start_ok) begin
        r_settle_cnt <= w_settle_init;
        r_decim_m1   <= w_decim_init;
        r_nrec       <= n_records;
        r_d          <= '0;
        r_rec_cnt    <= '0;
        r_overflow   <= 1'b0;
      end
      if ((r_state == ST_SETTLE) && (r_settle_cnt != '0))
        r_settle_cnt <= r_settle_cnt - CNT_WIDTH'(1);
      if (r_state == ST_RUN) begin
        r_d <= w_capture ? '0 : r_d + CNT_WIDTH'(1);
        // saturating so continuous mode never wraps into a false final record
        if (w_capture && (r_rec_cnt != '1))
          r_rec_cnt <= r_rec_cnt + CNT_WIDTH'(1);
      end
    end
  end

  axis_out_slot #(.W(DOUT_WIDTH)) u_slot (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_capture),
    .i_data  (phase_in),
    .i_last  (w_final),
    .i_ready (m_axis_tready),
    .o_data  (m_axis_tdata),
    .o_last  (m_axis_tlast),
    .o_valid (m_axis_tvalid),
    .o_drop  (w_drop)
  );

  assign acc_on   = r_acc_on;
  assign busy     = (r_state != ST_IDLE);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_phase_acq_ctrl.sv
// Directed bench for phase_acq_ctrl; expected beats go into a queue and a forked
// monitor pops and compares them on every AXI-Stream handshake.
module tb_phase_acq_ctrl;

  logic               clk = 1'b0;
  logic               resetn;
  logic               start, stop;
  logic [15:0]        n_settle, n_decim, n_records;
  logic signed [31:0] phase_in;
  logic               acc_on;
  logic [31:0]        tdata;
  logic               tvalid, tready, tlast;
  logic               busy, overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  phase_acq_ctrl #(.DOUT_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .stop          (stop),
    .n_settle      (n_settle),
    .n_decim       (n_decim),
    .n_records     (n_records),
    .phase_in      (phase_in),
    .acc_on        (acc_on),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .busy          (busy),
    .overflow      (overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    phase_in = phase_in + 32'sd1;
  endtask

  task automatic push(input int d, input logic l);
    exp_q.push_back({l, 32'(d)});
  endtask

  // leaves the bench in cycle C1; phase_in in cycle Ck equals p0+k
  task automatic begin_acq(input int s, input int d, input int r, input int p0);
    n_settle  = 16'(s);
    n_decim   = 16'(d);
    n_records = 16'(r);
    phase_in  = 32'(p0);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    logic [32:0] e;
    int n_on;
    int k;
    int p0;

    resetn = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b0;
    n_settle = '0; n_decim = '0; n_records = '0; phase_in = '0;

    fork
      forever begin
        @(negedge clk);
        if (resetn && tvalid && tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {31'd0, tlast, tdata}, 64'h1_0000_0000_dead);
          end else begin
            e = exp_q.pop_front();
            chk("beat_tdata", 64'(tdata), 64'(e[31:0]));
            chk("beat_tlast", 64'(tlast), 64'(e[32]));
          end
        end
      end
    join_none

    #12;
    chk("rst_acc_on", 64'(acc_on), 0);
    chk("rst_tvalid", 64'(tvalid), 0);
    chk("rst_tlast", 64'(tlast), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_tdata", 64'(tdata), 0);
    #8 resetn = 1'b1;
    tick();

    // basic run: settle 4, decim 10, 3 records
    p0 = -20;
    push(p0 + 14, 1'b0); push(p0 + 24, 1'b0); push(p0 + 34, 1'b1);
    tready = 1'b1;
    begin_acq(4, 10, 3, p0);
    chk("t1_settle_busy", 64'(busy), 1);
    chk("t1_settle_acc", 64'(acc_on), 0);
    n_on = 0; k = 1;
    while (k < 200) begin
      if (acc_on) n_on++;
      else if (n_on > 0) break;
      tick(); k++;
    end
    chk("t1_acc_on_cycles", 64'(n_on), 30);
    chk("t1_end_cycle", 64'(k), 35);
    chk("t1_busy_falls", 64'(busy), 0);
    repeat (3) tick();
    chk("t1_overflow", 64'(overflow), 0);

    // backpressure: decim 2, tready low C0..C7
    p0 = 1000;
    push(p0 + 3, 1'b0); push(p0 + 9, 1'b1);
    tready = 1'b0;
    begin_acq(1, 2, 4, p0);
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (c >= 4 && c <= 7) begin
        chk("t2_hold_valid", 64'(tvalid), 1);
        chk("t2_hold_tdata", 64'(tdata), 64'(32'(p0 + 3)));
        chk("t2_hold_tlast", 64'(tlast), 0);
      end
      if (c == 8) begin
        chk("t2_overflow", 64'(overflow), 1);
        tready = 1'b1;
      end
      if (c == 10) chk("t2_done_busy", 64'(busy), 0);
    end

    // abort in continuous mode with a beat pending
    p0 = 5000;
    push(p0 + 7, 1'b0);
    tready = 1'b0;
    begin_acq(2, 5, 0, p0);
    for (int c = 2; c <= 23; c++) begin
      tick();
      if (c == 17) chk("t3_run_acc", 64'(acc_on), 1);
      if (c == 18) stop = 1'b1;
      if (c == 19) begin
        stop = 1'b0;
        chk("t3_abort_acc", 64'(acc_on), 0);
        chk("t3_abort_busy", 64'(busy), 0);
        chk("t3_pending_valid", 64'(tvalid), 1);
        chk("t3_pending_last", 64'(tlast), 0);
      end
      if (c == 20) tready = 1'b1;
      if (c == 22) chk("t3_drained", 64'(tvalid), 0);
    end

    // zero parameters: one settle cycle, two back-to-back captures
    p0 = -3;
    push(p0 + 2, 1'b0); push(p0 + 3, 1'b1);
    tready = 1'b1;
    begin_acq(0, 0, 2, p0);
    chk("t4_ovf_cleared", 64'(overflow), 0);
    chk("t4_settle_acc", 64'(acc_on), 0);
    tick();
    chk("t4_run_c2", 64'(acc_on), 1);
    tick();
    chk("t4_run_c3", 64'(acc_on), 1);
    tick();
    chk("t4_idle_c4", 64'(acc_on), 0);
    chk("t4_idle_busy", 64'(busy), 0);
    repeat (3) tick();

    // asynchronous reset mid-run discards the pending beat
    p0 = 77;
    tready = 1'b0;
    begin_acq(1, 3, 0, p0);
    repeat (7) tick();
    chk("t5_pre_ovf", 64'(overflow), 1);
    chk("t5_pre_valid", 64'(tvalid), 1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_rst_acc", 64'(acc_on), 0);
    chk("t5_rst_valid", 64'(tvalid), 0);
    chk("t5_rst_tdata", 64'(tdata), 0);
    chk("t5_rst_busy", 64'(busy), 0);
    chk("t5_rst_ovf", 64'(overflow), 0);
    chk("t5_rst_last", 64'(tlast), 0);
    #3 resetn = 1'b1;
    tick();
    p0 = 300;
    push(p0 + 2, 1'b1);
    tready = 1'b1;
    begin_acq(1, 1, 1, p0);
    tick();
    chk("t5_restart_acc", 64'(acc_on), 1);
    tick();
    chk("t5_restart_busy", 64'(busy), 0);
    repeat (2) tick();

    // start+stop in IDLE, then start during RUN
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("t6_startstop_busy", 64'(busy), 0);
    p0 = 40;
    push(p0 + 5, 1'b0); push(p0 + 9, 1'b1);
    begin_acq(1, 4, 2, p0);
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (c == 3) begin
        n_settle = 16'd0; n_decim = 16'd1; n_records = 16'd1; start = 1'b1;
      end
      if (c == 4) start = 1'b0;
      if (c == 9)  chk("t6_busy_c9", 64'(busy), 1);
      if (c == 10) chk("t6_busy_c10", 64'(busy), 0);
    end
    chk("t6_overflow", 64'(overflow), 0);

    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
